// File: rtl/slice_ff_pkg.sv
// Shared types and limits for the slice flip-flop bank and its readback engine.
// Optional feature macro: SLICE_FF_BANK_PARITY_EN (appends an even-parity bit to the readback stream).
package slice_ff_pkg;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_DEPTH = 4;

    typedef enum logic {
        RB_IDLE  = 1'b0,
        RB_SHIFT = 1'b1
    } rb_state_t;

    // Number of bits in one readback stream for a bank of the given width.
    function automatic int unsigned calc_nbits(input int unsigned width);
`ifdef SLICE_FF_BANK_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/slice_ff_bank_if.sv
// Readback capture/stream handshake between the FF bank and its consumer.
interface slice_ff_bank_if;

    logic CAP;
    logic CAP_BUSY;
    logic RB_VALID;
    logic RB_READY;
    logic RB_DOUT;
    logic RB_LAST;

    modport master (
        output CAP,
        output RB_READY,
        input  CAP_BUSY,
        input  RB_VALID,
        input  RB_DOUT,
        input  RB_LAST
    );

    modport slave (
        input  CAP,
        input  RB_READY,
        output CAP_BUSY,
        output RB_VALID,
        output RB_DOUT,
        output RB_LAST
    );

endinterface

// File: rtl/slice_ff_chan.sv
// One flip-flop channel: DEPTH-stage clock-enabled register chain with synchronous set/reset value.
module slice_ff_chan #(
    parameter int unsigned DEPTH = 1,
    parameter logic        SRVAL = 1'b0
) (
    input  logic c_i,
    input  logic sr_i,
    input  logic ce_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] stg_q;
    logic [DEPTH-1:0] stg_d;

    // Stage 0 takes D, every later stage takes its predecessor.
    always_comb begin
        stg_d = DEPTH'({stg_q, d_i});
    end

    always_ff @(posedge c_i) begin
        if (sr_i) begin
            stg_q <= {DEPTH{SRVAL}};
        end else if (ce_i) begin
            stg_q <= stg_d;
        end
    end

    assign q_o = stg_q[DEPTH-1];

endmodule

// File: rtl/slice_ff_bank.sv
// WIDTH-channel FF bank with per-bit set/reset values and a serial, non-intrusive readback port.
// Optional feature macro: SLICE_FF_BANK_PARITY_EN.
module slice_ff_bank
    import slice_ff_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      DEPTH = 1,
    parameter logic [WIDTH-1:0] SRVAL = {WIDTH{1'b0}}
) (
    input  logic             C,
    input  logic             SR,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    slice_ff_bank_if.slave   rb
);

    localparam int unsigned      NBITS    = calc_nbits(WIDTH);
    localparam int unsigned      CNT_W    = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("slice_ff_bank: WIDTH out of range");
    end
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("slice_ff_bank: DEPTH out of range");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        slice_ff_chan #(
            .DEPTH (DEPTH),
            .SRVAL (SRVAL[i])
        ) u_chan (
            .c_i  (C),
            .sr_i (SR),
            .ce_i (CE),
            .d_i  (D[i]),
            .q_o  (Q[i])
        );
    end

    rb_state_t        state_q, state_d;
    logic [NBITS-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [NBITS-1:0] cap_word;
    logic             xfer;

`ifdef SLICE_FF_BANK_PARITY_EN
    assign cap_word = {^Q, Q};
`else
    assign cap_word = Q;
`endif

    assign xfer = valid_q & rb.RB_READY;

    // Readback FSM: snapshot Q on CAP, then shift LSB-first one bit per accepted handshake.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        case (state_q)
            RB_IDLE: begin
                if (rb.CAP) begin
                    state_d  = RB_SHIFT;
                    shadow_d = cap_word;
                    cnt_d    = '0;
                    valid_d  = 1'b1;
                end
            end
            RB_SHIFT: begin
                if (xfer) begin
                    shadow_d = shadow_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_q) begin
                        state_d = RB_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = RB_IDLE;
                valid_d = 1'b0;
            end
        endcase
        last_d = valid_d && (cnt_d == LAST_IDX);
    end

    always_ff @(posedge C) begin
        if (SR) begin
            state_q  <= RB_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign rb.RB_VALID = valid_q;
    assign rb.CAP_BUSY = valid_q;
    assign rb.RB_DOUT  = shadow_q[0];
    assign rb.RB_LAST  = last_q;

endmodule

// File: tb/tb_slice_ff_bank.sv
// Directed self-checking bench: DEPTH=1 bank (SRVAL=A5) for reset/readback, DEPTH=3 bank for pipeline latency.
module tb_slice_ff_bank;

`ifdef SLICE_FF_BANK_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       sr;
    logic       ce;
    logic [7:0] d;
    logic [7:0] q1;
    logic [7:0] q3;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    slice_ff_bank_if rb1 ();
    slice_ff_bank_if rb3 ();

    slice_ff_bank #(.WIDTH(8), .DEPTH(1), .SRVAL(8'hA5)) u_dut1 (
        .C (clk), .SR (sr), .CE (ce), .D (d), .Q (q1), .rb (rb1)
    );

    slice_ff_bank #(.WIDTH(8), .DEPTH(3), .SRVAL(8'h3C)) u_dut3 (
        .C (clk), .SR (sr), .CE (ce), .D (d), .Q (q3), .rb (rb3)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] stream_of(input logic [7:0] v);
        return {^v, v};
    endfunction

    // Expects the first bit already presented; accepts every bit with RB_READY=1.
    task automatic run_stream(input string tag, input logic [8:0] exp);
        rb1.RB_READY = 1'b1;
        for (int i = 0; i < NB; i++) begin
            check({tag, "_valid"}, 64'(rb1.RB_VALID), 64'(1));
            check({tag, "_dout"},  64'(rb1.RB_DOUT),  64'(exp[i]));
            check({tag, "_last"},  64'(rb1.RB_LAST),  64'(i == NB - 1));
            tick();
        end
        check({tag, "_end_valid"}, 64'(rb1.RB_VALID), 64'(0));
        check({tag, "_end_busy"},  64'(rb1.CAP_BUSY), 64'(0));
    endtask

    initial begin
        logic [3:0] rdy_pat;
        logic [8:0] exp;
        int         idx;
        int         xfers;

        sr = 1'b1; ce = 1'b1; d = 8'hFF;
        rb1.CAP = 1'b0; rb1.RB_READY = 1'b0;
        rb3.CAP = 1'b0; rb3.RB_READY = 1'b0;
        #2;

        // Reset overrides CE
        tick();
        check("rst_q1",    64'(q1), 64'hA5);
        check("rst_q3",    64'(q3), 64'h3C);
        check("rst_valid", 64'(rb1.RB_VALID), 64'(0));
        check("rst_busy",  64'(rb1.CAP_BUSY), 64'(0));
        check("rst_dout",  64'(rb1.RB_DOUT),  64'(0));
        check("rst_last",  64'(rb1.RB_LAST),  64'(0));
        sr = 1'b0;
        tick();
        check("rel_q1", 64'(q1), 64'hFF);
        check("rel_q3", 64'(q3), 64'h3C);

        // DEPTH=3 latency with a CE=0 bubble
        sr = 1'b1; tick(); sr = 1'b0;
        ce = 1'b1; d = 8'h11; tick();
        check("pipe_e1_q3", 64'(q3), 64'h3C);
        ce = 1'b0; d = 8'h22; tick();
        check("pipe_e2_q3", 64'(q3), 64'h3C);
        check("pipe_e2_q1", 64'(q1), 64'h11);
        ce = 1'b1; d = 8'h33; tick();
        check("pipe_e3_q3", 64'(q3), 64'h3C);
        d = 8'h44; tick();
        check("pipe_e4_q3", 64'(q3), 64'h11);
        check("pipe_e4_q1", 64'(q1), 64'h44);

        // Readback of 0x96 with RB_READY held high
        d = 8'h96; tick();
        ce = 1'b0; d = 8'h00;
        check("load_q1", 64'(q1), 64'h96);
        rb1.CAP = 1'b1; rb1.RB_READY = 1'b1;
        tick();
        rb1.CAP = 1'b0;
        check("cap_busy", 64'(rb1.CAP_BUSY), 64'(1));
        run_stream("rb96", stream_of(8'h96));

        // Back-pressure 1,0,0,1 plus an ignored mid-stream CAP
        rb1.CAP = 1'b1; tick(); rb1.CAP = 1'b0;
        rdy_pat = 4'b1001;
        exp = stream_of(8'h96);
        idx = 0; xfers = 0;
        for (int c = 0; c < 64 && idx < NB; c++) begin
            rb1.RB_READY = rdy_pat[c % 4];
            rb1.CAP = (c == 5);
            check("bp_valid", 64'(rb1.RB_VALID), 64'(1));
            check("bp_dout",  64'(rb1.RB_DOUT),  64'(exp[idx]));
            check("bp_last",  64'(rb1.RB_LAST),  64'(idx == NB - 1));
            tick();
            if (rb1.RB_READY) begin
                idx++;
                xfers++;
            end
        end
        rb1.CAP = 1'b0; rb1.RB_READY = 1'b1;
        check("bp_xfers", 64'(xfers), 64'(NB));
        check("bp_end_valid", 64'(rb1.RB_VALID), 64'(0));
        tick();
        check("bp_no_requeue", 64'(rb1.RB_VALID), 64'(0));

        // SR after three accepted bits aborts the stream and reloads SRVAL
        rb1.CAP = 1'b1; tick(); rb1.CAP = 1'b0;
        tick(); tick(); tick();
        check("ab_mid_valid", 64'(rb1.RB_VALID), 64'(1));
        sr = 1'b1; tick(); sr = 1'b0;
        check("ab_valid", 64'(rb1.RB_VALID), 64'(0));
        check("ab_busy",  64'(rb1.CAP_BUSY), 64'(0));
        check("ab_q1",    64'(q1), 64'hA5);
        rb1.CAP = 1'b1; tick(); rb1.CAP = 1'b0;
        run_stream("rbA5", stream_of(8'hA5));

        // CAP held high: one idle cycle between streams
        ce = 1'b1; d = 8'h07; tick(); ce = 1'b0;
        check("load07_q1", 64'(q1), 64'h07);
        rb1.CAP = 1'b1; tick();
        run_stream("rb07a", stream_of(8'h07));
        tick();
        rb1.CAP = 1'b0;
        check("hold_recap_valid", 64'(rb1.RB_VALID), 64'(1));
        run_stream("rb07b", stream_of(8'h07));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
